// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, column word type and the InvMixColumns FSM encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [31:0] col_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } imc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Higher multiples reuse the x2/x4/x8 chain so each is just XORs of xtime outputs.
  function automatic logic [7:0] gmul09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul09 = x8 ^ x;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul0b = x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul0d = x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul0e = x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumn of one 32-bit column; byte 0 sits in the MSB.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  col_word_t col_i,
  output col_word_t col_o
);

  logic [7:0] a0_s, a1_s, a2_s, a3_s;

  assign a0_s = col_i[31:24];
  assign a1_s = col_i[23:16];
  assign a2_s = col_i[15:8];
  assign a3_s = col_i[7:0];

  assign col_o[31:24] = gmul0e(a0_s) ^ gmul0b(a1_s) ^ gmul0d(a2_s) ^ gmul09(a3_s);
  assign col_o[23:16] = gmul09(a0_s) ^ gmul0e(a1_s) ^ gmul0b(a2_s) ^ gmul0d(a3_s);
  assign col_o[15:8]  = gmul0d(a0_s) ^ gmul09(a1_s) ^ gmul0e(a2_s) ^ gmul0b(a3_s);
  assign col_o[7:0]   = gmul0b(a0_s) ^ gmul0d(a1_s) ^ gmul09(a2_s) ^ gmul0e(a3_s);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per clock through a single shared column unit,
// sequenced by a start/busy/done handshake.
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  imc_state_e   state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] data_out_q, data_out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [6:0]   col_msb_s;
  col_word_t    col_sel_s;
  col_word_t    col_mix_s;

  // Column c occupies bits [127-32c -: 32].
  assign col_msb_s = 7'd127 - {col_q, 5'd0};
  assign col_sel_s = work_q[col_msb_s -: 32];

  inv_mix_column_word u_col (
    .col_i (col_sel_s),
    .col_o (col_mix_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      col_q      <= 2'd0;
      work_q     <= 128'd0;
      data_out_q <= 128'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      work_q     <= work_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (col_q == 2'd3) state_d = ST_IDLE;
        else               state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    work_d     = work_q;
    col_d      = col_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d = data_in;
          col_d  = 2'd0;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        work_d[col_msb_s -: 32] = col_mix_s;
        col_d = col_q + 2'd1;
        // Last column: publish the completed state in the same edge it is formed.
        if (col_q == 2'd3) begin
          data_out_d = work_d;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        col_d  = 2'd0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter: known vectors, random round trips through
// a forward MixColumns model, handshake corner cases and mid-run reset.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  inv_mix_columns_iter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  // Generic GF(2^8) shift-and-add multiply.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    logic       carry;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      carry = x[7];
      x = {x[6:0], 1'b0} ^ (carry ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product on every column; coef[k] multiplies byte (r+k) mod 4.
  function automatic logic [127:0] mat_mix(input logic [127:0] s, input logic [31:0] coefs);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    for (int k = 0; k < 4; k++) coef[k] = coefs[31 - 8*k -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(coef[(j - rr + 4) % 4], a[j]);
        r[127 - 32*c - 8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return mat_mix(s, 32'h0E0B0D09);
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    return mat_mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Issue one block and wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
    @(negedge clk);
    start   = 1'b1;
    data_in = din;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = rnd128();
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    dout = data_out;
  endtask

  vec_t         vecs [4];
  logic [127:0] res, a_blk, c_blk, x, y;
  int           lat;
  int           lat_bad;

  initial begin
    vecs[0] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[1] = '{{4{32'h8e4da1bc}}, {4{32'hdb135345}}};
    vecs[2] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
    vecs[3] = '{{4{32'h01010101}}, {4{32'h01010101}}};

    reset   = 1'b1;
    start   = 1'b1;
    data_in = rnd128();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", data_out, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].din, res, lat);
      chk($sformatf("vec%0d_data", i), res, vecs[i].dexp);
      chk($sformatf("vec%0d_model", i), ref_inv(vecs[i].din), vecs[i].dexp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
    end

    lat_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      x = rnd128();
      y = ref_fwd(x);
      run_block(y, res, lat);
      chk($sformatf("roundtrip%0d", i), res, x);
      if (lat != 4) lat_bad++;
    end
    chk("roundtrip_latency_bad", 128'(lat_bad), 128'd0);

    // Restart attempts while busy are ignored; start on the done cycle chains the next block.
    a_blk = rnd128();
    c_blk = rnd128();
    @(negedge clk);
    start   = 1'b1;
    data_in = a_blk;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start   = 1'b1;
      data_in = rnd128();
      chk($sformatf("hs_busy_c%0d", i), {127'd0, busy}, {127'd0, 1'b1});
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    chk("hs_done_early", {127'd0, done}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hs_done_c4", {127'd0, done}, {127'd0, 1'b1});
    chk("hs_first_result", data_out, ref_inv(a_blk));
    start   = 1'b1;
    data_in = c_blk;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = rnd128();
    chk("hs_done_pulse", {127'd0, done}, 128'd0);
    chk("hs_second_busy", {127'd0, busy}, {127'd0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hs_hold_out%0d", i), data_out, ref_inv(a_blk));
      chk($sformatf("hs_no_done%0d", i), {127'd0, done}, 128'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("hs_second_done", {127'd0, done}, {127'd0, 1'b1});
    chk("hs_second_result", data_out, ref_inv(c_blk));
    @(posedge clk);
    @(negedge clk);
    chk("hs_done_single", {127'd0, done}, 128'd0);

    // Reset two edges into RUN must abort without exposing partial state.
    @(negedge clk);
    start   = 1'b1;
    data_in = rnd128();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_data_out", data_out, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    lat_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== 128'd0) lat_bad++;
    end
    chk("rst_quiet_after", 128'(lat_bad), 128'd0);
    x = rnd128();
    run_block(x, res, lat);
    chk("rst_next_result", res, ref_inv(x));
    chk("rst_next_latency", 128'(lat), 128'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
